mem_arbiter: RTL

- Two-requester, round-robin arbiter and sequencer for the single-port 32-bit data memory driven by `MAIN` (`en`/`RW`/`dataIN`).
- Accepts one request at a time from either port, drives exactly one memory access, and returns a one-cycle response to the granted requester.
- Sits between the core-side requesters (fetch/load-store path and debug/loader path) and the memory.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-memory arbiter, reused by the memory model and the MAIN top.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie, the one not granted last wins.
module rr_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data memory: one accepted request drives
// exactly one memory access and earns a one-cycle response. Handshake: accept = valid && ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              last_grant;
    logic              cur_id;
    logic [3:0]        wait_cnt;
    logic [1:0]        pick;
    logic              accept;
    logic [DATA_W-1:0] rsp_data;

    rr_pick2 u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (last_grant),
        .grant  (pick)
    );

    // Ready is the only combinational output; it is forced low while reset is held.
    assign req0_ready = !rst && (state == S_IDLE) && pick[0];
    assign req1_ready = !rst && (state == S_IDLE) && pick[1];
    assign accept     = (state == S_IDLE) && (pick != 2'b00);
    assign rsp_data   = (mem_rw == RW_READ) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_ISSUE;
            S_ISSUE: next_state = (mem_rw == RW_WRITE) ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // The mem_* registers double as the request latch, so they hold between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en <= accept;
            if (accept) begin
                cur_id     <= pick[1];
                last_grant <= pick[1];
                mem_rw     <= pick[1] ? req1_rw    : req0_rw;
                mem_addr   <= pick[1] ? req1_addr  : req0_addr;
                mem_wdata  <= pick[1] ? req1_wdata : req0_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= 4'(MEM_LAT - 1);
        end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Response registers load on the edge entering RESP, which for reads is the edge leaving WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else if ((next_state == S_RESP) && (state != S_RESP)) begin
            rsp0_valid <= !cur_id;
            rsp1_valid <= cur_id;
            rsp0_rdata <= cur_id ? '0 : rsp_data;
            rsp1_rdata <= cur_id ? rsp_data : '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end
    end

endmodule
